fetch_sequencer: RTL and testbench

Sequencing controller for the 8-bit fetch stage. Owns the program counter, drives the instruction-memory address, and loads the IF/ID pipeline register. Applies hazard stalls and relative-jump redirects resolved in decode, and squashes the wrong-path fetch. Sits between the instruction memory and the decode stage; the hazard unit and the jump decoder are its only control sources.

---
 rtl/fetch_sequencer.sv | 101 ++++++++++
 tb/tb_fetch_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: owns the PC, loads IF/ID, applies stalls, jump redirects and wrong-path squash.
// Optional feature macro: FETCH_HALT_EN (jump-to-self freezes the sequencer in HALT).
module fetch_sequencer (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       stall,
  input  logic       jump,
  input  logic [7:0] jaddress,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_data,
  output logic [7:0] ifid_instr,
  output logic [7:0] ifid_pc,
  output logic       ifid_valid,
  output logic       halted
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t     state_r;
  logic [7:0] pc_r;
  logic [7:0] ifid_instr_r;
  logic [7:0] ifid_pc_r;
  logic       ifid_valid_r;
  logic       jump_q_s;
  logic [7:0] target_s;

  // A jump reported against a bubble refers to no real instruction.
  assign jump_q_s = jump & ifid_valid_r;
  assign target_s = ifid_pc_r + jaddress;

  assign imem_addr  = pc_r;
  assign ifid_instr = ifid_instr_r;
  assign ifid_pc    = ifid_pc_r;
  assign ifid_valid = ifid_valid_r;

`ifdef FETCH_HALT_EN
  logic halted_r;
  assign halted = halted_r;
`else
  assign halted = 1'b0;
`endif

  // Sequencer state, PC and IF/ID register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r      <= ST_BOOT;
      pc_r         <= 8'h00;
      ifid_instr_r <= 8'h00;
      ifid_pc_r    <= 8'h00;
      ifid_valid_r <= 1'b0;
`ifdef FETCH_HALT_EN
      halted_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_BOOT: begin
          state_r      <= ST_RUN;
          ifid_valid_r <= 1'b0;
        end
        ST_RUN: begin
          if (jump_q_s) begin
`ifdef FETCH_HALT_EN
            if (jaddress == 8'h00) begin
              state_r      <= ST_HALT;
              halted_r     <= 1'b1;
              ifid_valid_r <= 1'b0;
            end else begin
              pc_r         <= target_s;
              ifid_valid_r <= 1'b0;
            end
`else
            pc_r         <= target_s;
            ifid_valid_r <= 1'b0;
`endif
          end else if (stall) begin
            pc_r         <= pc_r;
            ifid_valid_r <= ifid_valid_r;
          end else begin
            ifid_instr_r <= imem_data;
            ifid_pc_r    <= pc_r;
            ifid_valid_r <= 1'b1;
            pc_r         <= pc_r + 8'd1;
          end
        end
        ST_HALT: begin
          pc_r         <= pc_r;
          ifid_valid_r <= 1'b0;
        end
        default: begin
          state_r      <= ST_BOOT;
          ifid_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: behavioural model compared every cycle plus directed literal checks.
// Works with or without FETCH_HALT_EN defined.
module tb_fetch_sequencer;

  logic       Clk;
  logic       Reset;
  logic       stall;
  logic       jump;
  logic [7:0] jaddress;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic [7:0] ifid_instr;
  logic [7:0] ifid_pc;
  logic       ifid_valid;
  logic       halted;

  logic [7:0] mem [256];

`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  // Model of the architectural state, as seen after the most recent edge.
  int m_pc, m_instr, m_ipc;
  bit m_valid, m_halt, m_boot;

  fetch_sequencer dut (
    .Clk(Clk), .Reset(Reset), .stall(stall), .jump(jump), .jaddress(jaddress),
    .imem_addr(imem_addr), .imem_data(imem_data), .ifid_instr(ifid_instr),
    .ifid_pc(ifid_pc), .ifid_valid(ifid_valid), .halted(halted)
  );

  assign imem_data = mem[imem_addr];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance one edge: derive the next state from the rules, then let the DUT take the edge.
  task automatic tick();
    int n_pc, n_instr, n_ipc;
    bit n_valid, n_halt, n_boot;
    n_pc = m_pc; n_instr = m_instr; n_ipc = m_ipc;
    n_valid = m_valid; n_halt = m_halt; n_boot = m_boot;
    if (Reset) begin
      n_pc = 0; n_instr = 0; n_ipc = 0; n_valid = 0; n_halt = 0; n_boot = 1;
    end else if (m_boot) begin
      n_boot = 0;
    end else if (m_halt) begin
      n_valid = 0;
    end else if (jump && m_valid) begin
      n_valid = 0;
      if (HALT_EN && jaddress == 8'h00) n_halt = 1;
      else n_pc = (m_ipc + int'(jaddress)) % 256;
    end else if (!stall) begin
      n_instr = mem[m_pc];
      n_ipc   = m_pc;
      n_valid = 1;
      n_pc    = (m_pc + 1) % 256;
    end
    @(posedge Clk);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_ipc = n_ipc;
    m_valid = n_valid; m_halt = n_halt; m_boot = n_boot;
  endtask

  // Compare every DUT output against the model once per cycle.
  always @(negedge Clk) begin
    if (checking) begin
      chk("m.imem_addr", imem_addr, 8'(m_pc));
      chk("m.ifid_valid", {7'd0, ifid_valid}, {7'd0, m_valid});
      chk("m.halted", {7'd0, halted}, {7'd0, m_halt});
      chk("m.ifid_pc", ifid_pc, 8'(m_ipc));
      chk("m.ifid_instr", ifid_instr, 8'(m_instr));
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[0] = 8'h10; mem[1] = 8'h11; mem[2] = 8'h12;
    Reset = 1'b1; stall = 1'b0; jump = 1'b0; jaddress = 8'h00;
    m_pc = 0; m_instr = 0; m_ipc = 0; m_valid = 0; m_halt = 0; m_boot = 1;

    tick();
    checking = 1'b1;
    tick();
    chk("rst.valid", {7'd0, ifid_valid}, 8'h00);
    chk("rst.addr", imem_addr, 8'h00);
    chk("rst.halted", {7'd0, halted}, 8'h00);

    // Boot cycle, then the first three fetches.
    Reset = 1'b0;
    tick();
    chk("boot.valid", {7'd0, ifid_valid}, 8'h00);
    chk("boot.addr", imem_addr, 8'h00);
    tick();
    chk("f0.instr", ifid_instr, 8'h10); chk("f0.pc", ifid_pc, 8'h00);
    chk("f0.valid", {7'd0, ifid_valid}, 8'h01); chk("f0.addr", imem_addr, 8'h01);
    tick();
    chk("f1.instr", ifid_instr, 8'h11); chk("f1.pc", ifid_pc, 8'h01);
    tick();
    chk("f2.instr", ifid_instr, 8'h12); chk("f2.pc", ifid_pc, 8'h02);
    for (int i = 0; i < 3; i++) tick();
    chk("pre_stall.pc", ifid_pc, 8'h05);

    // Three stalled edges hold everything.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.pc", ifid_pc, 8'h05);
      chk("stall.addr", imem_addr, 8'h06);
    end
    stall = 1'b0;
    tick();
    chk("unstall.pc", ifid_pc, 8'h06);

    // Jump wins over stall: 6 + 0x1A = 0x20.
    jump = 1'b1; stall = 1'b1; jaddress = 8'h1A;
    tick();
    chk("js.valid", {7'd0, ifid_valid}, 8'h00);
    chk("js.addr", imem_addr, 8'h20);
    jump = 1'b0; stall = 1'b0;
    tick();
    chk("js.tgt", ifid_pc, 8'h20);

    // Backward jump 0x20 + 0xF0 = 0x10, then jump against the bubble is ignored.
    jump = 1'b1; jaddress = 8'hF0;
    tick();
    chk("jb.addr", imem_addr, 8'h10);
    chk("jb.valid", {7'd0, ifid_valid}, 8'h00);
    tick();
    chk("jq.pc", ifid_pc, 8'h10);
    chk("jq.valid", {7'd0, ifid_valid}, 8'h01);
    chk("jq.addr", imem_addr, 8'h11);

    // Wrap: jump to 0xFE and run across 0xFF.
    jaddress = 8'hEE;
    tick();
    jump = 1'b0;
    tick(); chk("wrap.fe", ifid_pc, 8'hFE);
    tick(); chk("wrap.ff", ifid_pc, 8'hFF);
    tick(); chk("wrap.00", ifid_pc, 8'h00); chk("wrap.addr", imem_addr, 8'h01);

    // Mixed directed pattern, checked by the model alone.
    for (int i = 1; i < 40; i++) begin
      stall = (i % 5 == 3);
      jump = (i % 7 == 2);
      jaddress = 8'(i * 37);
      tick();
    end

    // Reset wins mid-stall and mid-jump.
    stall = 1'b1; jump = 1'b1; Reset = 1'b1;
    tick();
    chk("rst2.addr", imem_addr, 8'h00);
    chk("rst2.valid", {7'd0, ifid_valid}, 8'h00);
    Reset = 1'b0; stall = 1'b0; jump = 1'b0;
    tick();
    tick();
    chk("rst2.instr", ifid_instr, 8'h10);

    // Jump-to-self.
    jump = 1'b1; jaddress = 8'h00;
    tick();
    jump = 1'b0;
`ifdef FETCH_HALT_EN
    chk("halt.halted", {7'd0, halted}, 8'h01);
    chk("halt.valid", {7'd0, ifid_valid}, 8'h00);
    for (int i = 0; i < 10; i++) begin
      stall = (i % 2 == 0);
      jump = (i % 3 == 0);
      tick();
      chk("halt.addr", imem_addr, 8'h01);
      chk("halt.hold", {7'd0, halted}, 8'h01);
    end
    stall = 1'b0; jump = 1'b0; Reset = 1'b1;
    tick();
    chk("unhalt.halted", {7'd0, halted}, 8'h00);
    chk("unhalt.addr", imem_addr, 8'h00);
    Reset = 1'b0;
    tick();
    chk("unhalt.boot", {7'd0, ifid_valid}, 8'h00);
`else
    chk("self.halted", {7'd0, halted}, 8'h00);
    chk("self.addr", imem_addr, 8'h00);
    tick();
    chk("self.pc", ifid_pc, 8'h00);
    chk("self.instr", ifid_instr, 8'h10);
    chk("self.valid", {7'd0, ifid_valid}, 8'h01);
`endif
    tick();
    tick();

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
